disp_sched: RTL and testbench

- Scheduler for the shared 4-digit multiplexed 7-segment display.
- Sequences the digit scan and the scrolling of an 8-character message buffer.
- Arbitrates display ownership between the scrolling message and keypad echo requests. Keypad has priority for a fixed hold time, then scrolling resumes where it stopped.
- Sits between the keypad/host logic and the display pins (led, cea..ced).

---
 rtl/disp_pkg.sv | 26 ++
 rtl/disp_timer.sv | 26 ++
 rtl/disp_sched.sv | 106 ++++++++++
 tb/tb_disp_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, state type and key-decode helpers for the display scheduler.
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Index 0 is the last element of the concatenation.
    localparam logic [7:0][6:0] MSG_DEFAULT = {
        7'b0100100, 7'b1000000, 7'b1111001, 7'b0011001,
        7'b1000000, 7'b1001110, 7'b1111001, 7'b0001001
    };

    typedef enum logic {S_SCROLL = 1'b0, S_KEY = 1'b1} state_t;

    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/disp_timer.sv
// Free-running divide-by-DIV counter; tick is high in the cycle the counter wraps.
module disp_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TOP = W'(DIV - 1);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    assign tick = (cnt == TOP);

    always_ff @(posedge clk) begin
        if (!rst)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + ONE;
    end

endmodule

// File: rtl/disp_sched.sv
// 4-digit display scheduler: digit scan, message scroll, and keypad echo
// that temporarily takes over the display.
module disp_sched
    import disp_pkg::*;
#(
    parameter int SCAN_DIV   = 65536,
    parameter int SCROLL_DIV = 67108864,
    parameter int HOLD_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_req,
    input  logic [7:0] key_code,
    output logic       key_gnt,
    output logic       key_err,
    input  logic       msg_we,
    input  logic [2:0] msg_addr,
    input  logic [6:0] msg_data,
    input  logic       pause,
    output logic       mode,
    output logic [6:0] led,
    output logic       cea,
    output logic       ceb,
    output logic       cec,
    output logic       ced
);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    logic            scan_tick;
    logic            scroll_tick;
    logic [1:0]      slot;
    logic [2:0]      roll;
    logic [2:0]      rd_idx;
    logic [HW-1:0]   hold;
    state_t          state;
    logic [6:0]      kpat;
    logic [7:0][6:0] mbuf;
    logic [6:0]      seg_nxt;
    logic            accept;
    logic            reject;

    disp_timer #(.DIV(SCAN_DIV)) u_scan (
        .clk (clk),
        .rst (rst),
        .tick(scan_tick)
    );

    disp_timer #(.DIV(SCROLL_DIV)) u_scroll (
        .clk (clk),
        .rst (rst),
        .tick(scroll_tick)
    );

    assign accept = key_req && is_onehot(key_code);
    assign reject = key_req && !is_onehot(key_code);
    assign rd_idx = roll + 3'(slot);
    assign mode   = (state == S_KEY);

    always_comb begin
        seg_nxt = mbuf[rd_idx];
        if (state == S_KEY)
            seg_nxt = (slot == 2'd3) ? kpat : SEG_BLANK;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot    <= 2'd0;
            roll    <= 3'd0;
            hold    <= '0;
            state   <= S_SCROLL;
            kpat    <= SEG_BLANK;
            mbuf    <= MSG_DEFAULT;
            led     <= SEG_BLANK;
            {ced, cec, ceb, cea} <= 4'b1111;
            key_gnt <= 1'b0;
            key_err <= 1'b0;
        end else begin
            if (scan_tick)
                slot <= slot + 2'd1;
            led <= seg_nxt;
            {ced, cec, ceb, cea} <= ~(4'b0001 << slot);
            key_gnt <= accept;
            key_err <= reject;
            // Display read above sees the pre-write buffer contents.
            if (msg_we)
                mbuf[msg_addr] <= msg_data;
            // An accept overrides a coincident tick: hold reloads, roll stays.
            if (accept) begin
                kpat  <= MSG_DEFAULT[onehot_idx(key_code)];
                hold  <= HOLD_LOAD;
                state <= S_KEY;
            end else if (scroll_tick) begin
                if (state == S_KEY) begin
                    hold <= hold - HOLD_ONE;
                    if (hold <= HOLD_ONE)
                        state <= S_SCROLL;
                end else if (!pause) begin
                    roll <= roll + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: directed sequences, an arbitration table,
// and randomized traffic against a time-based behavioural model.
module tb_disp_sched;

    localparam int SD = 4;
    localparam int RD = 32;
    localparam int HT = 2;

    logic       clk = 1'b0;
    logic       rst, key_req, msg_we, pause;
    logic [7:0] key_code;
    logic [2:0] msg_addr;
    logic [6:0] msg_data;
    logic       key_gnt, key_err, mode, cea, ceb, cec, ced;
    logic [6:0] led;

    int total = 0;
    int bad   = 0;

    logic [6:0] def_msg [8];

    // Behavioural model: time since reset drives both dividers.
    logic [6:0] m_buf [8];
    int         t, m_roll, m_hold;
    logic       m_key;
    logic [6:0] m_kpat;
    logic [6:0] e_led;
    logic [3:0] e_ce;
    logic       e_gnt, e_err;

    typedef struct {
        logic       req;
        logic [7:0] code;
        logic       gnt;
        logic       err;
        logic       md;
    } vec_t;
    vec_t vecs [5];

    disp_sched #(.SCAN_DIV(SD), .SCROLL_DIV(RD), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst(rst), .key_req(key_req), .key_code(key_code),
        .key_gnt(key_gnt), .key_err(key_err), .msg_we(msg_we),
        .msg_addr(msg_addr), .msg_data(msg_data), .pause(pause), .mode(mode),
        .led(led), .cea(cea), .ceb(ceb), .cec(cec), .ced(ced)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
        end
    endtask

    task automatic model_edge();
        int slot;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_buf[i] = def_msg[i];
            t = 0; m_roll = 0; m_hold = 0; m_key = 1'b0; m_kpat = 7'h7f;
            e_led = 7'h7f; e_ce = 4'hf; e_gnt = 1'b0; e_err = 1'b0;
            return;
        end
        slot = (t / SD) % 4;
        if (m_key) e_led = (slot == 3) ? m_kpat : 7'h7f;
        else       e_led = m_buf[(m_roll + slot) % 8];
        e_ce = 4'hf;
        e_ce[slot] = 1'b0;
        e_gnt = key_req && ($countones(key_code) == 1);
        e_err = key_req && ($countones(key_code) != 1);
        if (e_gnt) begin
            for (int i = 0; i < 8; i++) if (key_code[i]) m_kpat = def_msg[i];
            m_hold = HT;
            m_key  = 1'b1;
        end else if (t % RD == RD - 1) begin
            if (m_key) begin
                m_hold--;
                if (m_hold == 0) m_key = 1'b0;
            end else if (!pause) begin
                m_roll = (m_roll + 1) % 8;
            end
        end
        if (msg_we) m_buf[msg_addr] = msg_data;
        t++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("outputs", 32'({led, ced, cec, ceb, cea, key_gnt, key_err, mode}),
                       32'({e_led, e_ce, e_gnt, e_err, m_key}));
    endtask

    task automatic step_to(input int n);
        while (t < n) step();
    endtask

    task automatic chk_disp(input string nm, input logic [6:0] l, input logic [3:0] ce);
        chk(nm, 32'({led, ced, cec, ceb, cea}), 32'({l, ce}));
    endtask

    initial begin
        logic [3:0] one;
        def_msg[0] = 7'b0001001; def_msg[1] = 7'b1111001;
        def_msg[2] = 7'b1001110; def_msg[3] = 7'b1000000;
        def_msg[4] = 7'b0011001; def_msg[5] = 7'b1111001;
        def_msg[6] = 7'b1000000; def_msg[7] = 7'b0100100;
        t = 0;
        rst = 1'b0; key_req = 1'b0; key_code = 8'h00; msg_we = 1'b0;
        msg_addr = 3'd0; msg_data = 7'h00; pause = 1'b0;

        repeat (3) step();
        chk("reset", 32'({led, ced, cec, ceb, cea, key_gnt, key_err, mode}), 32'({7'h7f, 4'hf, 3'b000}));
        rst = 1'b1;

        // Scan sequence: four cycles per slot, one enable low.
        for (int s = 0; s < 4; s++) begin
            repeat (SD) step();
            one = 4'b0001 << s;
            chk_disp("scan", def_msg[s], ~one);
        end

        // Three ticks (t=31,63,95) -> roll 3.
        step_to(97);  chk_disp("roll3 slot0", 7'b1000000, 4'b1110);
        step_to(101); chk_disp("roll3 slot1", 7'b0011001, 4'b1101);
        step_to(109); chk_disp("roll3 slot3", 7'b1000000, 4'b0111);
        step_to(257); chk_disp("roll wrap", 7'b0001001, 4'b1110);

        // Key echo of index 4.
        key_req = 1'b1; key_code = 8'b0001_0000;
        step();
        key_req = 1'b0; key_code = 8'h00;
        chk("key gnt", 32'({key_gnt, mode}), 32'(2'b11));
        step();
        chk("key gnt pulse", 32'(key_gnt), 32'(0));
        step_to(269); chk_disp("key slot3", 7'b0011001, 4'b0111);
        step_to(273); chk_disp("key slot0", 7'b1111111, 4'b1110);
        step_to(319); chk("key hold", 32'(mode), 32'(1));
        step_to(320); chk("key release", 32'(mode), 32'(0));
        step_to(321); chk_disp("roll kept", 7'b0001001, 4'b1110);

        // Arbitration table.
        vecs[0] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'hff, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            key_req = vecs[i].req; key_code = vecs[i].code;
            step();
            chk("arb", 32'({key_gnt, key_err, mode}), 32'({vecs[i].gnt, vecs[i].err, vecs[i].md}));
        end
        key_req = 1'b0; key_code = 8'h00;

        // Accept coincident with tick at t=415, reload at t=447.
        step_to(415);
        chk("idle before tick", 32'(mode), 32'(0));
        key_req = 1'b1; key_code = 8'h02;
        step();
        key_req = 1'b0;
        chk("gnt on tick", 32'({key_gnt, mode}), 32'(2'b11));
        step_to(447);
        key_req = 1'b1; key_code = 8'h08;
        step();
        key_req = 1'b0; key_code = 8'h00;
        chk("reload gnt", 32'({key_gnt, mode}), 32'(2'b11));
        step_to(511); chk("reload hold", 32'(mode), 32'(1));
        step();       chk("reload release", 32'(mode), 32'(0));
        step_to(513); chk_disp("no advance", 7'b0001001, 4'b1110);

        // Write while paused, then reset restores the buffer.
        pause = 1'b1;
        msg_we = 1'b1; msg_addr = 3'd0; msg_data = 7'b0000000;
        step();
        msg_we = 1'b0;
        step_to(529); chk_disp("write shows", 7'b0000000, 4'b1110);
        rst = 1'b0;
        step();
        chk("reset again", 32'({led, ced, cec, ceb, cea, key_gnt, key_err, mode}), 32'({7'h7f, 4'hf, 3'b000}));
        rst = 1'b1; pause = 1'b0;
        step();
        chk_disp("buffer restored", 7'b0001001, 4'b1110);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst      = ($urandom_range(299, 0) != 0);
            key_req  = ($urandom_range(24, 0) == 0);
            key_code = ($urandom_range(1, 0) == 1) ? 8'(1 << $urandom_range(7, 0)) : 8'($urandom);
            msg_we   = ($urandom_range(19, 0) == 0);
            msg_addr = 3'($urandom);
            msg_data = 7'($urandom);
            if ($urandom_range(49, 0) == 0) pause = ~pause;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
